// File: rtl/player_health_controller.sv
// Health-bar damage tracker: latches a bar width on load, removes pixels per
// tick-qualified hit, enforces an invulnerability window and flags death.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | after reset; triggers ignored, all outputs 0
// ST_ALIVE   | accepting hits on tick_centi & object_trigger_signal
// ST_INVULN  | post-hit window, counting down tick_centi pulses
// ST_DEAD    | bar depleted; left only by reset or a new load
module player_health_controller #(
  parameter int INVULN_TICKS = 3,
  parameter int MAX_HITS     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_centi,
  input  logic       reset_healt_status,
  input  logic [9:0] healt_bar_w,
  input  logic [6:0] healt_bar_sensitivity,
  input  logic       object_trigger_signal,
  output logic [9:0] healt_bar_w_minus,
  output logic [9:0] healt_bar_remaining,
  output logic       hit_flash,
  output logic       is_dead,
  output logic       dead_pulse,
  output logic [7:0] hit_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ALIVE  = 2'd1;
  localparam logic [1:0] ST_INVULN = 2'd2;
  localparam logic [1:0] ST_DEAD   = 2'd3;

  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_TICKS);
  localparam logic [7:0] MAX_HITS_C  = 8'(MAX_HITS);

  logic [1:0]  state_q, state_d;
  logic [9:0]  width_q, width_d;
  logic [9:0]  w_minus_q, w_minus_d;
  logic [9:0]  remaining_q, remaining_d;
  logic [7:0]  hit_count_q, hit_count_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hit_flash_q, hit_flash_d;
  logic        is_dead_q, is_dead_d;
  logic        dead_pulse_q, dead_pulse_d;

  logic [10:0] dmg_sum;
  logic [9:0]  dmg_capped;
  logic [7:0]  hits_inc;

  always_comb begin
    // 11-bit sum so the clamp to the latched width cannot wrap
    dmg_sum    = {1'b0, w_minus_q} + {4'b0, healt_bar_sensitivity};
    dmg_capped = (dmg_sum > {1'b0, width_q}) ? width_q : dmg_sum[9:0];
    hits_inc   = (hit_count_q == MAX_HITS_C) ? hit_count_q : hit_count_q + 8'd1;

    state_d      = state_q;
    width_d      = width_q;
    w_minus_d    = w_minus_q;
    hit_count_d  = hit_count_q;
    cnt_d        = cnt_q;
    dead_pulse_d = 1'b0;

    if (reset_healt_status) begin
      width_d      = healt_bar_w;
      w_minus_d    = '0;
      hit_count_d  = '0;
      cnt_d        = '0;
      state_d      = (healt_bar_w == 10'd0) ? ST_DEAD : ST_ALIVE;
      dead_pulse_d = (healt_bar_w == 10'd0);
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (tick_centi && object_trigger_signal) begin
            w_minus_d   = dmg_capped;
            hit_count_d = hits_inc;
            if (dmg_capped == width_q) begin
              state_d      = ST_DEAD;
              dead_pulse_d = 1'b1;
            end else begin
              state_d = ST_INVULN;
              cnt_d   = INVULN_LOAD;
            end
          end
        end
        ST_INVULN: begin
          if (tick_centi) begin
            if (cnt_q <= 8'd1) begin
              cnt_d   = 8'd0;
              state_d = ST_ALIVE;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    remaining_d = width_d - w_minus_d;
    hit_flash_d = (state_d == ST_INVULN);
    is_dead_d   = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      w_minus_q    <= '0;
      remaining_q  <= '0;
      hit_count_q  <= '0;
      cnt_q        <= '0;
      hit_flash_q  <= 1'b0;
      is_dead_q    <= 1'b0;
      dead_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      w_minus_q    <= w_minus_d;
      remaining_q  <= remaining_d;
      hit_count_q  <= hit_count_d;
      cnt_q        <= cnt_d;
      hit_flash_q  <= hit_flash_d;
      is_dead_q    <= is_dead_d;
      dead_pulse_q <= dead_pulse_d;
    end
  end

  assign healt_bar_w_minus   = w_minus_q;
  assign healt_bar_remaining = remaining_q;
  assign hit_flash           = hit_flash_q;
  assign is_dead             = is_dead_q;
  assign dead_pulse          = dead_pulse_q;
  assign hit_count           = hit_count_q;

endmodule

// File: tb/tb_player_health_controller.sv
// Directed bench for player_health_controller; MAX_HITS is lowered to 5 so
// hit-count saturation is reachable quickly.
module tb_player_health_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_centi = 1'b0;
  logic       reset_healt_status = 1'b0;
  logic [9:0] healt_bar_w = '0;
  logic [6:0] healt_bar_sensitivity = '0;
  logic       object_trigger_signal = 1'b0;
  logic [9:0] healt_bar_w_minus;
  logic [9:0] healt_bar_remaining;
  logic       hit_flash;
  logic       is_dead;
  logic       dead_pulse;
  logic [7:0] hit_count;

  int n_checks = 0;
  int n_fail   = 0;

  player_health_controller #(.INVULN_TICKS(3), .MAX_HITS(5)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .tick_centi            (tick_centi),
    .reset_healt_status    (reset_healt_status),
    .healt_bar_w           (healt_bar_w),
    .healt_bar_sensitivity (healt_bar_sensitivity),
    .object_trigger_signal (object_trigger_signal),
    .healt_bar_w_minus     (healt_bar_w_minus),
    .healt_bar_remaining   (healt_bar_remaining),
    .hit_flash             (hit_flash),
    .is_dead               (is_dead),
    .dead_pulse            (dead_pulse),
    .hit_count             (hit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock with the given tick/trigger/load; outputs sampled 1ns after the edge
  task automatic step(input logic t, input logic tr, input logic ld);
    tick_centi            = t;
    object_trigger_signal = tr;
    reset_healt_status    = ld;
    @(posedge clk);
    #1;
    tick_centi         = 1'b0;
    reset_healt_status = 1'b0;
  endtask

  // one tick period of five clocks, tick on the first
  task automatic tick5(input logic tr);
    step(1'b1, tr, 1'b0);
    repeat (4) step(1'b0, tr, 1'b0);
  endtask

  task automatic load(input int w, input int s);
    healt_bar_w           = 10'(w);
    healt_bar_sensitivity = 7'(s);
    step(1'b0, object_trigger_signal, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wm"},    int'(healt_bar_w_minus), 0);
    chk({tag, "_rem"},   int'(healt_bar_remaining), 0);
    chk({tag, "_flash"}, int'(hit_flash), 0);
    chk({tag, "_dead"},  int'(is_dead), 0);
    chk({tag, "_pulse"}, int'(dead_pulse), 0);
    chk({tag, "_hits"},  int'(hit_count), 0);
  endtask

  initial begin
    // power-on reset
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    chk_all_zero("por");

    // IDLE ignores hits
    repeat (3) step(1'b1, 1'b1, 1'b0);
    chk_all_zero("idle");

    // periodic hits with invulnerability window
    object_trigger_signal = 1'b0;
    load(100, 10);
    chk("l100_rem", int'(healt_bar_remaining), 100);
    chk("l100_flash", int'(hit_flash), 0);
    for (int k = 1; k <= 12; k++) begin
      tick5(1'b1);
      chk($sformatf("p_wm%0d", k), int'(healt_bar_w_minus), 10 * ((k - 1) / 4 + 1));
      chk($sformatf("p_hits%0d", k), int'(hit_count), (k - 1) / 4 + 1);
      chk($sformatf("p_flash%0d", k), int'(hit_flash), (k % 4 != 0) ? 1 : 0);
    end
    chk("p_rem", int'(healt_bar_remaining), 70);

    // depletion to DEAD with saturated damage
    load(25, 10);
    repeat (8) tick5(1'b1);
    chk("d_wm20", int'(healt_bar_w_minus), 20);
    step(1'b1, 1'b1, 1'b0);
    chk("d_wm", int'(healt_bar_w_minus), 25);
    chk("d_rem", int'(healt_bar_remaining), 0);
    chk("d_dead", int'(is_dead), 1);
    chk("d_pulse", int'(dead_pulse), 1);
    chk("d_hits", int'(hit_count), 3);
    chk("d_flash", int'(hit_flash), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("d_pulse_off", int'(dead_pulse), 0);
    chk("d_dead_hold", int'(is_dead), 1);
    repeat (4) tick5(1'b1);
    chk("d_wm_hold", int'(healt_bar_w_minus), 25);
    chk("d_hits_hold", int'(hit_count), 3);
    chk("d_pulse_hold", int'(dead_pulse), 0);

    // triggers only on non-tick cycles
    object_trigger_signal = 1'b0;
    load(100, 10);
    chk("nt_dead", int'(is_dead), 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("nt_wm", int'(healt_bar_w_minus), 0);
    chk("nt_hits", int'(hit_count), 0);

    // zero sensitivity still counts as a hit
    healt_bar_sensitivity = 7'd0;
    step(1'b1, 1'b1, 1'b0);
    chk("s0_wm", int'(healt_bar_w_minus), 0);
    chk("s0_hits", int'(hit_count), 1);
    chk("s0_flash", int'(hit_flash), 1);
    chk("s0_rem", int'(healt_bar_remaining), 100);

    // zero-width load dies immediately
    object_trigger_signal = 1'b0;
    load(0, 10);
    chk("w0_dead", int'(is_dead), 1);
    chk("w0_pulse", int'(dead_pulse), 1);
    chk("w0_hits", int'(hit_count), 0);
    chk("w0_rem", int'(healt_bar_remaining), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("w0_pulse_off", int'(dead_pulse), 0);

    // load wins over a simultaneous hit
    load(100, 40);
    step(1'b1, 1'b1, 1'b0);
    chk("lw_wm40", int'(healt_bar_w_minus), 40);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("lw_alive", int'(hit_flash), 0);
    healt_bar_w = 10'd100;
    step(1'b1, 1'b1, 1'b1);
    chk("lw_wm", int'(healt_bar_w_minus), 0);
    chk("lw_hits", int'(hit_count), 0);
    chk("lw_flash", int'(hit_flash), 0);
    chk("lw_dead", int'(is_dead), 0);
    chk("lw_rem", int'(healt_bar_remaining), 100);

    // reset in INVULN clears everything and returns to IDLE
    object_trigger_signal = 1'b0;
    load(100, 30);
    step(1'b1, 1'b1, 1'b0);
    chk("ri_wm30", int'(healt_bar_w_minus), 30);
    chk("ri_flash", int'(hit_flash), 1);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    chk_all_zero("ri");
    repeat (10) step(1'b1, 1'b1, 1'b0);
    chk_all_zero("ri_idle");

    // hit_count saturates at MAX_HITS=5 (hits on ticks 1,5,...,29)
    object_trigger_signal = 1'b0;
    load(1000, 1);
    repeat (30) step(1'b1, 1'b1, 1'b0);
    chk("sat_wm", int'(healt_bar_w_minus), 8);
    chk("sat_hits", int'(hit_count), 5);
    chk("sat_rem", int'(healt_bar_remaining), 992);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
